// File: rtl/cic_pkg.sv
// Shared constants and types for the CIC decimator.
package cic_pkg;
  localparam int N_STAGES = 4;
  localparam int OS_MAX   = 7;

  typedef logic [2:0] os_sel_t;

  // Accumulator width that holds the full R^N gain at the largest ratio.
  function automatic int acc_w(input int dw);
    return dw + N_STAGES * OS_MAX;
  endfunction
endpackage

// File: rtl/cic_comb_stage.sv
// One comb differentiator (M=1): y = u - u_prev, where the delay only advances on en.
module cic_comb_stage #(
  parameter int AW = 44
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [AW-1:0] u,
  output logic signed [AW-1:0] y
);
  logic signed [AW-1:0] d;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) d <= '0;
    else if (en)         d <= u;
  end

  assign y = u - d;
endmodule

// File: rtl/cic_filter.sv
// Hogenauer CIC decimator: 4 integrators at input rate, 4 combs per strobe,
// output normalised by an arithmetic shift of 4*os_sel bits.
module cic_filter
  import cic_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_div,
  input  logic [2:0]           os_sel,
  input  logic signed [DW-1:0] data_in,
  output logic signed [DW-1:0] data_out
);
  localparam int AW = acc_w(DW);

  os_sel_t              os_q;
  logic                 clk_div_q;
  logic                 os_change;
  logic                 stb;
  logic [4:0]           shamt;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] integ [N_STAGES];
  logic signed [AW-1:0] stage [N_STAGES+1];

  assign x_ext     = {{(AW-DW){data_in[DW-1]}}, data_in};
  assign os_change = (os_sel != os_q);
  // A ratio change restarts the filter, so no strobe is taken on that edge.
  assign stb       = !os_change && ((os_q == '0) || (clk_div && !clk_div_q));
  assign shamt     = 5'(N_STAGES) * 5'(os_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      os_q      <= '0;
      clk_div_q <= 1'b0;
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else begin
      os_q <= os_sel;
      if (os_change) begin
        clk_div_q <= 1'b0;
        for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
      end else begin
        clk_div_q <= clk_div;
        integ[0]  <= integ[0] + x_ext;
        for (int k = 1; k < N_STAGES; k++) integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  assign stage[0] = integ[N_STAGES-1];

  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    cic_comb_stage #(.AW(AW)) u_comb (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (os_change),
      .en      (stb),
      .u       (stage[g]),
      .y       (stage[g+1])
    );
  end

  // Wrapped integrator state is fine: the combs undo it modulo 2^AW.
  always_ff @(posedge clk) begin
    if (!reset_n)  data_out <= '0;
    else if (stb)  data_out <= DW'(stage[N_STAGES] >>> shamt);
  end
endmodule

// File: tb/tb_cic_filter.sv
// Directed bench for cic_filter: DC table, reset, bypass ramp, Nyquist null, ratio change.
module tb_cic_filter;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clk_div = 1'b0;
  logic [2:0]           os_sel = 3'd0;
  logic signed [DW-1:0] data_in = '0;
  logic signed [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;
  int div_cnt = 0;
  logic alt = 1'b0;
  logic signed [DW-1:0] exp_q[$];

  typedef struct {
    logic [2:0]           os;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] expv;
  } dc_vec_t;

  dc_vec_t vecs[6];

  cic_filter #(.DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_div  (clk_div),
    .os_sel   (os_sel),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic signed [DW-1:0] act,
                       input logic signed [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_range(input string name, input logic signed [DW-1:0] act,
                             input int lo, input int hi);
    checks++;
    if (int'(act) < lo || int'(act) > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs are sampled there too.
  task automatic cycle(input int period);
    @(posedge clk);
    @(negedge clk);
    if (alt) data_in = -data_in;
    if (period > 1) begin
      div_cnt = (div_cnt + 1) % period;
      clk_div = (div_cnt >= period / 2);
    end
  endtask

  task automatic do_reset(input int ncyc, input logic check_en, input logic signed [DW-1:0] x);
    reset_n = 1'b0;
    clk_div = 1'b0;
    div_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      data_in = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (check_en) check("reset_hold", data_out, '0);
    end
    reset_n = 1'b1;
    data_in = x;
  endtask

  // Wait for n strobes, then one more edge so the last strobe has reached data_out.
  task automatic run_strobes(input int period, input int n);
    int seen;
    int budget;
    logic prev;
    seen = 0;
    budget = period * (n + 3) + 20;
    while (seen < n && budget > 0) begin
      prev = clk_div;
      cycle(period);
      budget--;
      if (period == 1 || (clk_div && !prev)) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: got %0d strobes required %0d", seen, n);
    end else begin
      cycle(period);
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    vecs[0] = '{os: 3'd2, x: 16'sd1000,   expv: 16'sd1000};
    vecs[1] = '{os: 3'd7, x: -16'sd32768, expv: -16'sd32768};
    vecs[2] = '{os: 3'd1, x: -16'sd1,     expv: -16'sd1};
    vecs[3] = '{os: 3'd3, x: 16'sd12345,  expv: 16'sd12345};
    vecs[4] = '{os: 3'd2, x: 16'sd32767,  expv: 16'sd32767};
    vecs[5] = '{os: 3'd4, x: -16'sd7,     expv: -16'sd7};

    @(negedge clk);

    // Reset hold, release, DC settle, then a one-cycle reset mid-stream.
    os_sel = 3'd2;
    do_reset(4, 1'b1, 16'sd1000);
    cycle(4);
    check("reset_release", data_out, '0);
    run_strobes(4, 6);
    check("dc_before_midreset", data_out, 16'sd1000);
    do_reset(1, 1'b1, 16'sd1000);
    run_strobes(4, 6);
    check("dc_after_midreset", data_out, 16'sd1000);

    // DC table: settle, then hold across further strobes.
    foreach (vecs[i]) begin
      os_sel = vecs[i].os;
      do_reset(2, 1'b0, vecs[i].x);
      run_strobes(1 << vecs[i].os, 6);
      check($sformatf("dc_settle[%0d]", i), data_out, vecs[i].expv);
      for (int j = 0; j < 2; j++) begin
        run_strobes(1 << vecs[i].os, 1);
        check($sformatf("dc_hold[%0d]", i), data_out, vecs[i].expv);
      end
    end

    // Bypass: output is the ramp delayed by five clocks, no gain change.
    os_sel = 3'd0;
    do_reset(2, 1'b0, 16'sd0);
    exp_q = {};
    for (int i = 0; i < 5; i++) exp_q.push_back('0);
    for (int m = 1; m <= 30; m++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bypass_ramp[%0d]", m), data_out, exp_q.pop_front());
      data_in = DW'(m);
      exp_q.push_back(DW'(m));
    end

    // Nyquist input is nulled by the R=4 comb response.
    os_sel = 3'd2;
    do_reset(2, 1'b0, 16'sd4000);
    alt = 1'b1;
    run_strobes(4, 8);
    check_range("nyquist_settle", data_out, -1, 1);
    for (int j = 0; j < 3; j++) begin
      run_strobes(4, 1);
      check_range("nyquist_hold", data_out, -1, 1);
    end
    alt = 1'b0;

    // Ratio change 2 -> 3 under DC 500: hold, restart, re-settle at R=8.
    os_sel = 3'd2;
    do_reset(2, 1'b0, 16'sd500);
    run_strobes(4, 6);
    check("os_change_before", data_out, 16'sd500);
    os_sel = 3'd3;
    clk_div = 1'b0;
    div_cnt = 0;
    cycle(8);
    check("os_change_hold", data_out, 16'sd500);
    run_strobes(8, 1);
    check_range("os_change_restart", data_out, 0, 499);
    run_strobes(8, 6);
    check("os_change_settle", data_out, 16'sd500);
    run_strobes(8, 1);
    check("os_change_hold2", data_out, 16'sd500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
